// File: rtl/maxpool_2x2_ctrl.sv
// 2x2 / stride-2 max-pooling sequencer: walks a feature map window by window,
// reads four samples per window and writes their signed maximum.
module maxpool_2x2_ctrl #(
   parameter int W1    = 9,
   parameter int IMG_W = 26,
   parameter int IMG_H = 26,
   parameter int RD_AW = 10,
   parameter int WR_AW = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             rd_en,
   output logic [RD_AW-1:0] rd_addr,
   input  logic [W1-1:0]    rd_data,
   output logic             wr_en,
   output logic [WR_AW-1:0] wr_addr,
   output logic [W1-1:0]    wr_data
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RD   = 3'd1;
   localparam logic [2:0] S_CAP  = 3'd2;
   localparam logic [2:0] S_WR   = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam logic [WR_AW-1:0] HALF_W  = WR_AW'(IMG_W / 2);
   localparam logic [WR_AW-1:0] HALF_H  = WR_AW'(IMG_H / 2);
   localparam logic [RD_AW-1:0] ROW_LEN = RD_AW'(IMG_W);

   logic [2:0]              state;
   logic [1:0]              k;
   logic [WR_AW-1:0]        pr;
   logic [WR_AW-1:0]        pc;
   logic signed [W1-1:0]    smp_p0 [4];
   logic signed [W1-1:0]    wr_max_p1;
   logic                    last_col;
   logic                    last_row;

   // Ties keep the earlier sample, so the result is always one of the inputs.
   function automatic logic signed [W1-1:0] max4(
      input logic signed [W1-1:0] a,
      input logic signed [W1-1:0] b,
      input logic signed [W1-1:0] c,
      input logic signed [W1-1:0] d
   );
      logic signed [W1-1:0] m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

   assign last_col = (pc == HALF_W - WR_AW'(1));
   assign last_row = (pr == HALF_H - WR_AW'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         k         <= '0;
         pr        <= '0;
         pc        <= '0;
         wr_max_p1 <= '0;
         for (int i = 0; i < 4; i++) smp_p0[i] <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  k     <= '0;
                  pr    <= '0;
                  pc    <= '0;
                  state <= S_RD;
               end
            end
            // p0: read data arrives one cycle behind each strobe
            S_RD: begin
               if (k != 2'd0) smp_p0[k - 2'd1] <= $signed(rd_data);
               if (k == 2'd3) state <= S_CAP;
               k <= k + 2'd1;
            end
            // p1: last sample lands here, so the maximum folds it in directly
            S_CAP: begin
               smp_p0[3] <= $signed(rd_data);
               wr_max_p1 <= max4(smp_p0[0], smp_p0[1], smp_p0[2], $signed(rd_data));
               state     <= S_WR;
            end
            S_WR: begin
               k <= '0;
               if (last_col) begin
                  pc <= '0;
                  if (last_row) begin
                     state <= S_DONE;
                  end else begin
                     pr    <= pr + WR_AW'(1);
                     state <= S_RD;
                  end
               end else begin
                  pc    <= pc + WR_AW'(1);
                  state <= S_RD;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy    = (state == S_RD) || (state == S_CAP) || (state == S_WR);
   assign done    = (state == S_DONE);
   assign rd_en   = (state == S_RD);
   assign wr_en   = (state == S_WR);
   assign wr_data = wr_max_p1;

   always_comb begin
      rd_addr = '0;
      if (state == S_RD) begin
         rd_addr = ((RD_AW'(pr) * ROW_LEN) << 1) + (RD_AW'(pc) << 1)
                 + (k[1] ? ROW_LEN : '0) + {{(RD_AW-1){1'b0}}, k[0]};
      end
   end

   always_comb begin
      wr_addr = '0;
      if (state == S_WR) wr_addr = pr * HALF_W + pc;
   end

endmodule

// File: tb/tb_maxpool_2x2_ctrl.sv
// Bench for maxpool_2x2_ctrl: a 4x4 instance for exact timing/corner cases and
// a 26x26 instance driven with random maps against a window-max reference.
module tb_maxpool_2x2_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // small instance
   logic       start_s, busy_s, done_s, rd_en_s, wr_en_s;
   logic [3:0] rd_addr_s;
   logic [8:0] rd_data_s, wr_data_s;
   logic [1:0] wr_addr_s;
   // big instance
   logic       start_b, busy_b, done_b, rd_en_b, wr_en_b;
   logic [9:0] rd_addr_b;
   logic [8:0] rd_data_b, wr_data_b;
   logic [7:0] wr_addr_b;

   maxpool_2x2_ctrl #(.W1(9), .IMG_W(4), .IMG_H(4), .RD_AW(4), .WR_AW(2)) u_small (
      .clk(clk), .rst(rst), .start(start_s), .busy(busy_s), .done(done_s),
      .rd_en(rd_en_s), .rd_addr(rd_addr_s), .rd_data(rd_data_s),
      .wr_en(wr_en_s), .wr_addr(wr_addr_s), .wr_data(wr_data_s));

   maxpool_2x2_ctrl #(.W1(9), .IMG_W(26), .IMG_H(26), .RD_AW(10), .WR_AW(8)) u_big (
      .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
      .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
      .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b));

   logic [8:0] mem_s [16];
   logic [8:0] mem_b [676];

   // Buffer models: one-cycle read latency, junk when not reading.
   always @(posedge clk) begin
      if (rd_en_s) rd_data_s <= mem_s[rd_addr_s];
      else         rd_data_s <= 9'($urandom);
      if (rd_en_b && rd_addr_b < 10'd676) rd_data_b <= mem_b[rd_addr_b];
      else                                rd_data_b <= 9'($urandom);
   end

   int wcyc_s[$], waddr_s[$], wdat_s[$], dcyc_s[$], rcyc_s[$], raddr_s[$];
   int wcyc_b[$], waddr_b[$], wdat_b[$], dcyc_b[$], rcyc_b[$], raddr_b[$];
   int busy_cnt_s, ovl_s, busy_cnt_b, ovl_b;

   always @(negedge clk) begin
      if (wr_en_s) begin
         wcyc_s.push_back(cyc); waddr_s.push_back(int'(wr_addr_s));
         wdat_s.push_back(int'($signed(wr_data_s)));
      end
      if (rd_en_s) begin rcyc_s.push_back(cyc); raddr_s.push_back(int'(rd_addr_s)); end
      if (done_s) dcyc_s.push_back(cyc);
      if (busy_s) busy_cnt_s++;
      if (rd_en_s && wr_en_s) ovl_s++;
      if (wr_en_b) begin
         wcyc_b.push_back(cyc); waddr_b.push_back(int'(wr_addr_b));
         wdat_b.push_back(int'($signed(wr_data_b)));
      end
      if (rd_en_b) begin rcyc_b.push_back(cyc); raddr_b.push_back(int'(rd_addr_b)); end
      if (done_b) dcyc_b.push_back(cyc);
      if (busy_b) busy_cnt_b++;
      if (rd_en_b && wr_en_b) ovl_b++;
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int qget(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -99999;
   endfunction

   // Reference: maximum of the four samples of window n of the 26x26 map.
   function automatic int ref_b(input int n);
      int pr, pc, base, m, v;
      pr = n / 13; pc = n % 13;
      base = 2 * pr * 26 + 2 * pc;
      m = -100000;
      foreach (mem_b[i]) begin
         if (i == base || i == base + 1 || i == base + 26 || i == base + 27) begin
            v = int'($signed(mem_b[i]));
            if (v > m) m = v;
         end
      end
      return m;
   endfunction

   task automatic clr_s();
      @(posedge clk);
      wcyc_s.delete(); waddr_s.delete(); wdat_s.delete();
      dcyc_s.delete(); rcyc_s.delete(); raddr_s.delete();
      busy_cnt_s = 0; ovl_s = 0;
   endtask

   task automatic clr_b();
      @(posedge clk);
      wcyc_b.delete(); waddr_b.delete(); wdat_b.delete();
      dcyc_b.delete(); rcyc_b.delete(); raddr_b.delete();
      busy_cnt_b = 0; ovl_b = 0;
   endtask

   task automatic pulse_s(output int t);
      @(negedge clk); start_s = 1'b1; t = cyc;
      @(negedge clk); start_s = 1'b0;
   endtask

   task automatic wait_done_s(input int need, input int limit);
      int n = 0;
      while (dcyc_s.size() < need && n < limit) begin @(negedge clk); n++; end
      chk("small_done_seen", int'(dcyc_s.size() >= need), 1);
      repeat (3) @(negedge clk);
   endtask

   task automatic chk_idle_s(input string tag);
      chk({tag, "_busy"}, int'(busy_s), 0);     chk({tag, "_done"}, int'(done_s), 0);
      chk({tag, "_rd_en"}, int'(rd_en_s), 0);   chk({tag, "_rd_addr"}, int'(rd_addr_s), 0);
      chk({tag, "_wr_en"}, int'(wr_en_s), 0);   chk({tag, "_wr_addr"}, int'(wr_addr_s), 0);
      chk({tag, "_wr_data"}, int'(wr_data_s), 0);
   endtask

   typedef struct {
      int s0, s1, s2, s3, exp;
   } win_t;

   initial begin
      win_t tbl[8];
      int   exp_ra[8];
      int   exp_wd[4];
      int   t, t2, base, r1, n;

      tbl[0] = '{-256,   -1, -128, -255,   -1};
      tbl[1] = '{  -5,   -5,   -5,   -5,   -5};
      tbl[2] = '{ 255, -256,    0,  254,  255};
      tbl[3] = '{   0,    0,    0,    1,    1};
      tbl[4] = '{   3,    7,    7,    2,    7};
      tbl[5] = '{  -1,   -2,   -3,   -4,   -1};
      tbl[6] = '{-100,  -50, -200,  -49,  -49};
      tbl[7] = '{ -10,  -20,  -30,  100,  100};
      exp_ra = '{0, 1, 4, 5, 2, 3, 6, 7};
      exp_wd = '{5, 7, 13, 15};

      rst = 1'b1; start_s = 1'b0; start_b = 1'b0;
      for (int i = 0; i < 16; i++) mem_s[i] = 9'(i);
      repeat (3) @(negedge clk);
      chk_idle_s("rst_small");
      chk("rst_big_busy", int'(busy_b), 0);    chk("rst_big_done", int'(done_b), 0);
      chk("rst_big_rd_en", int'(rd_en_b), 0);  chk("rst_big_rd_addr", int'(rd_addr_b), 0);
      chk("rst_big_wr_en", int'(wr_en_b), 0);  chk("rst_big_wr_addr", int'(wr_addr_b), 0);
      chk("rst_big_wr_data", int'(wr_data_b), 0);
      rst = 1'b0;

      // 4x4 counting map
      clr_s();
      pulse_s(t);
      wait_done_s(1, 60);
      chk("cnt_nwr", wcyc_s.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk("cnt_wr_addr", qget(waddr_s, i), i);
         chk("cnt_wr_data", qget(wdat_s, i), exp_wd[i]);
         chk("cnt_wr_cyc", qget(wcyc_s, i), t + 6 * (i + 1));
      end
      for (int i = 0; i < 8; i++) chk("cnt_rd_addr", qget(raddr_s, i), exp_ra[i]);
      chk("cnt_first_rd", qget(rcyc_s, 0), t + 1);
      chk("cnt_nrd", rcyc_s.size(), 16);
      chk("cnt_done_cyc", qget(dcyc_s, 0), t + 25);
      chk("cnt_ndone", dcyc_s.size(), 1);
      chk("cnt_busy", busy_cnt_s, 24);
      chk("cnt_overlap", ovl_s, 0);

      // signed-ordering windows from the table
      for (int c = 0; c < 2; c++) begin
         for (int w = 0; w < 4; w++) begin
            base = (w / 2) * 8 + (w % 2) * 2;
            mem_s[base]     = 9'(tbl[c*4+w].s0);
            mem_s[base + 1] = 9'(tbl[c*4+w].s1);
            mem_s[base + 4] = 9'(tbl[c*4+w].s2);
            mem_s[base + 5] = 9'(tbl[c*4+w].s3);
         end
         clr_s();
         pulse_s(t);
         wait_done_s(1, 60);
         for (int w = 0; w < 4; w++) chk("tbl_max", qget(wdat_s, w), tbl[c*4+w].exp);
      end

      // start held high while busy, through DONE, and into the following IDLE
      for (int i = 0; i < 16; i++) mem_s[i] = 9'(i);
      clr_s();
      @(negedge clk); start_s = 1'b1; t = cyc;
      repeat (27) @(negedge clk);
      start_s = 1'b0;
      wait_done_s(2, 80);
      chk("hold_ndone", dcyc_s.size(), 2);
      chk("hold_done0", qget(dcyc_s, 0), t + 25);
      chk("hold_done1", qget(dcyc_s, 1), t + 51);
      chk("hold_nwr", wcyc_s.size(), 8);
      chk("hold_wr3_cyc", qget(wcyc_s, 3), t + 24);
      chk("hold_wr4_cyc", qget(wcyc_s, 4), t + 32);
      chk("hold_rd16_cyc", qget(rcyc_s, 16), t + 27);
      chk("hold_rd16_addr", qget(raddr_s, 16), 0);

      // reset during the WR cycle of window 3
      clr_s();
      pulse_s(t);
      while (cyc < t + 24) @(negedge clk);
      chk("abort_wr_en", int'(wr_en_s), 1);
      chk("abort_wr_addr", int'(wr_addr_s), 3);
      rst = 1'b1;
      @(negedge clk);
      chk_idle_s("abort_after");
      rst = 1'b0;
      repeat (30) @(negedge clk);
      chk("abort_nwr", wcyc_s.size(), 4);
      chk("abort_ndone", dcyc_s.size(), 0);
      clr_s();
      pulse_s(t);
      wait_done_s(1, 60);
      chk("restart_rd_addr", qget(raddr_s, 0), 0);
      chk("restart_first_rd", qget(rcyc_s, 0), t + 1);
      for (int i = 0; i < 4; i++) chk("restart_wr_data", qget(wdat_s, i), exp_wd[i]);

      // 26x26 random map, then a back-to-back second map
      foreach (mem_b[i]) mem_b[i] = 9'($urandom);
      clr_b();
      @(negedge clk); start_b = 1'b1; t = cyc;
      @(negedge clk); start_b = 1'b0;
      while (cyc < t + 1016) @(negedge clk);
      chk("big_nwr", wcyc_b.size(), 169);
      for (int i = 0; i < 169; i++) begin
         chk("big_wr_addr", qget(waddr_b, i), i);
         chk("big_wr_data", qget(wdat_b, i), ref_b(i));
      end
      chk("big_last_wr", qget(wcyc_b, 168), t + 1014);
      chk("big_done_cyc", qget(dcyc_b, 0), t + 1015);
      chk("big_ndone", dcyc_b.size(), 1);
      chk("big_busy", busy_cnt_b, 1014);
      chk("big_overlap", ovl_b, 0);
      chk("big_nrd", rcyc_b.size(), 676);
      r1 = rcyc_b.size();
      n  = wcyc_b.size();
      start_b = 1'b1; t2 = cyc;
      foreach (mem_b[i]) mem_b[i] = 9'($urandom);
      @(negedge clk); start_b = 1'b0;
      while (dcyc_b.size() < 2 && cyc < t2 + 1100) @(negedge clk);
      repeat (3) @(negedge clk);
      chk("b2b_ndone", dcyc_b.size(), 2);
      chk("b2b_first_rd", qget(rcyc_b, r1), t + 1017);
      chk("b2b_first_addr", qget(raddr_b, r1), 0);
      chk("b2b_nwr", wcyc_b.size(), 338);
      for (int i = 0; i < 169; i++) begin
         chk("b2b_wr_addr", qget(waddr_b, n + i), i);
         chk("b2b_wr_data", qget(wdat_b, n + i), ref_b(i));
      end
      chk("b2b_done_cyc", qget(dcyc_b, 1), t2 + 1015);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
